// File: rtl/blob_pkg.sv
// Shared constants, FSM state encoding and helpers for the blob frame scheduler.
package blob_pkg;

   localparam int unsigned IMG_COL  = 640;
   localparam int unsigned IMG_ROW  = 480;
   localparam int unsigned COUNT_W  = 8;
   localparam int unsigned PIX_W    = 19;
   localparam int unsigned FRAMES_W = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      KICK   = 3'd2,
      STREAM = 3'd3,
      WAIT   = 3'd4,
      DONE   = 3'd5
   } state_t;

   // Index of the last pixel of a frame, in pixel-counter width.
   function automatic logic [PIX_W-1:0] pix_last(input int unsigned col, input int unsigned row);
      return PIX_W'(col * row - 1);
   endfunction

endpackage

// File: rtl/blob_timeout_timer.sv
// Cycle counter that flags when an enabled wait has lasted TIMEOUT cycles.
module blob_timeout_timer #(
   parameter int unsigned TIMEOUT = 1048576
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire_c
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Fires on the cycle whose increment brings the count to TIMEOUT.
   assign o_expire_c = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/blob_frame_scheduler.sv
// Arms on request, kicks the blob counter at a frame start, streams one frame of
// binarized pixels into it and collects the resulting blob count.
module blob_frame_scheduler
   import blob_pkg::*;
#(
   parameter int unsigned IMG_COL = blob_pkg::IMG_COL,
   parameter int unsigned IMG_ROW = blob_pkg::IMG_ROW,
   parameter int unsigned TIMEOUT = 1048576
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_continuous,
   input  logic                i_frame_start,
   input  logic                i_pix_valid,
   input  logic                i_pix_bin,
   output logic                o_blob_valid,
   output logic                o_blob_seq,
   input  logic                i_blob_done,
   input  logic [COUNT_W-1:0]  i_blob_count,
   output logic [COUNT_W-1:0]  o_count,
   output logic                o_count_valid,
   output logic                o_busy,
   output logic                o_err,
   output logic [FRAMES_W-1:0] o_frames
);

   localparam logic [PIX_W-1:0] PIX_LAST = pix_last(IMG_COL, IMG_ROW);

   state_t               r_state;
   state_t               w_next;
   logic [PIX_W-1:0]     r_pix_cnt;
   logic [PIX_W-1:0]     w_pix_cnt_d;
   logic                 r_bad;
   logic                 w_bad_d;
   logic                 r_blob_valid;
   logic                 r_blob_seq;
   logic                 w_blob_seq_d;
   logic [COUNT_W-1:0]   r_count;
   logic [COUNT_W-1:0]   w_count_d;
   logic                 r_count_valid;
   logic                 w_count_valid_d;
   logic                 r_busy;
   logic                 r_err;
   logic                 w_err_d;
   logic [FRAMES_W-1:0]  r_frames;
   logic [FRAMES_W-1:0]  w_frames_d;
   logic                 w_timer_load;
   logic                 w_timer_en;
   logic                 w_timer_expire;

   // The timer is held at zero outside WAIT so it counts from WAIT entry.
   assign w_timer_load = (r_state != WAIT);
   assign w_timer_en   = (r_state == WAIT);

   blob_timeout_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_timer_load),
      .i_en       (w_timer_en),
      .o_expire_c (w_timer_expire)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= IDLE;
         r_pix_cnt     <= '0;
         r_bad         <= 1'b0;
         r_blob_valid  <= 1'b0;
         r_blob_seq    <= 1'b0;
         r_count       <= '0;
         r_count_valid <= 1'b0;
         r_busy        <= 1'b0;
         r_err         <= 1'b0;
         r_frames      <= '0;
      end else begin
         r_state       <= w_next;
         r_pix_cnt     <= w_pix_cnt_d;
         r_bad         <= w_bad_d;
         r_blob_valid  <= (w_next == KICK);
         r_blob_seq    <= w_blob_seq_d;
         r_count       <= w_count_d;
         r_count_valid <= w_count_valid_d;
         r_busy        <= (w_next != IDLE);
         r_err         <= w_err_d;
         r_frames      <= w_frames_d;
      end
   end

   // Next state and next register values.
   always_comb begin
      w_next          = r_state;
      w_pix_cnt_d     = r_pix_cnt;
      w_bad_d         = r_bad;
      w_blob_seq_d    = 1'b0;
      w_count_d       = r_count;
      w_count_valid_d = 1'b0;
      w_err_d         = r_err;
      w_frames_d      = r_frames;

      unique case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next  = ARM;
               w_err_d = 1'b0;
            end
         end
         ARM: begin
            if (i_frame_start) begin
               w_next = KICK;
            end
         end
         KICK: begin
            w_next      = STREAM;
            w_pix_cnt_d = '0;
            w_bad_d     = 1'b0;
         end
         STREAM: begin
            // A gap spoils the rest of the frame: feed zeros until the pixel count is met.
            if (i_pix_valid) begin
               w_blob_seq_d = i_pix_bin && !r_bad;
            end else begin
               w_err_d = 1'b1;
               w_bad_d = 1'b1;
            end
            if (r_pix_cnt == PIX_LAST) begin
               w_next = WAIT;
            end else begin
               w_pix_cnt_d = r_pix_cnt + PIX_W'(1);
            end
         end
         WAIT: begin
            if (i_blob_done) begin
               w_next = DONE;
               if (!r_bad) begin
                  w_count_d       = i_blob_count;
                  w_count_valid_d = 1'b1;
                  w_frames_d      = r_frames + FRAMES_W'(1);
               end
            end else if (w_timer_expire) begin
               w_next  = IDLE;
               w_err_d = 1'b1;
            end
         end
         DONE: begin
            w_next = i_continuous ? ARM : IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign o_blob_valid  = r_blob_valid;
   assign o_blob_seq    = r_blob_seq;
   assign o_count       = r_count;
   assign o_count_valid = r_count_valid;
   assign o_busy        = r_busy;
   assign o_err         = r_err;
   assign o_frames      = r_frames;

endmodule

// File: tb/tb_blob_frame_scheduler.sv
// Directed self-checking bench for blob_frame_scheduler on a small 8x4 frame.
module tb_blob_frame_scheduler;

   localparam int unsigned IMG_COL = 8;
   localparam int unsigned IMG_ROW = 4;
   localparam int unsigned TIMEOUT = 16;
   localparam int          NPIX    = 32;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_start;
   logic        i_continuous;
   logic        i_frame_start;
   logic        i_pix_valid;
   logic        i_pix_bin;
   logic        o_blob_valid;
   logic        o_blob_seq;
   logic        i_blob_done;
   logic [7:0]  i_blob_count;
   logic [7:0]  o_count;
   logic        o_count_valid;
   logic        o_busy;
   logic        o_err;
   logic [15:0] o_frames;

   int n_vec  = 0;
   int n_err  = 0;
   int kick_cnt = 0;
   int cv_cnt   = 0;

   blob_frame_scheduler #(
      .IMG_COL (IMG_COL),
      .IMG_ROW (IMG_ROW),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_start       (i_start),
      .i_continuous  (i_continuous),
      .i_frame_start (i_frame_start),
      .i_pix_valid   (i_pix_valid),
      .i_pix_bin     (i_pix_bin),
      .o_blob_valid  (o_blob_valid),
      .o_blob_seq    (o_blob_seq),
      .i_blob_done   (i_blob_done),
      .i_blob_count  (i_blob_count),
      .o_count       (o_count),
      .o_count_valid (o_count_valid),
      .o_busy        (o_busy),
      .o_err         (o_err),
      .o_frames      (o_frames)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Pulse counters for the kick and result strobes.
   always @(negedge i_clk) begin
      if (o_blob_valid === 1'b1) kick_cnt++;
      if (o_count_valid === 1'b1) cv_cnt++;
   end

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      step();
      i_rst_n = 1'b1;
   endtask

   // From ARM: frame start, kick, then one full frame of pixels with an optional gap.
   task automatic drive_frame(input logic [31:0] pat, input int gap_at);
      logic bad;
      logic exp;
      i_frame_start = 1'b1; i_pix_valid = 1'b1; i_pix_bin = 1'b1;
      step();
      i_frame_start = 1'b0; i_pix_valid = 1'b0; i_pix_bin = 1'b0;
      n_vec++;
      if (o_blob_valid !== 1'b1) begin n_err++; $display("FAIL kick: got %b expected 1", o_blob_valid); end
      step();
      n_vec++;
      if (o_blob_valid !== 1'b0) begin n_err++; $display("FAIL kick_len: got %b expected 0", o_blob_valid); end
      bad = 1'b0;
      for (int i = 0; i < NPIX; i++) begin
         i_pix_valid = (i != gap_at);
         i_pix_bin   = pat[i];
         if (i == gap_at) bad = 1'b1;
         exp = bad ? 1'b0 : pat[i];
         step();
         n_vec++;
         if (o_blob_seq !== exp) begin n_err++; $display("FAIL seq[%0d]: got %b expected %b", i, o_blob_seq, exp); end
      end
      i_pix_valid = 1'b0;
      i_pix_bin   = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      i_start = 1'b0; i_continuous = 1'b0; i_frame_start = 1'b0;
      i_pix_valid = 1'b0; i_pix_bin = 1'b0; i_blob_done = 1'b0; i_blob_count = 8'h00;
      #3;
      n_vec++; if (o_blob_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", o_blob_valid); end
      n_vec++; if (o_blob_seq !== 1'b0) begin n_err++; $display("FAIL rst_seq: got %b expected 0", o_blob_seq); end
      n_vec++; if (o_count !== 8'h00) begin n_err++; $display("FAIL rst_count: got %h expected 00", o_count); end
      n_vec++; if (o_count_valid !== 1'b0) begin n_err++; $display("FAIL rst_cv: got %b expected 0", o_count_valid); end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b expected 0", o_busy); end
      n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b expected 0", o_err); end
      n_vec++; if (o_frames !== 16'h0000) begin n_err++; $display("FAIL rst_frames: got %h expected 0000", o_frames); end
      step();
      i_rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      int kick0;
      int cv0;
      kick0 = kick_cnt; cv0 = cv_cnt;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL busy_arm: got %b expected 1", o_busy); end
      i_blob_done = 1'b1; i_blob_count = 8'h77;
      step();
      i_blob_done = 1'b0;
      n_vec++; if (o_count !== 8'h00) begin n_err++; $display("FAIL done_in_arm: got %h expected 00", o_count); end
      drive_frame(32'hA5C3_0F96, -1);
      step();
      n_vec++; if (o_blob_seq !== 1'b0) begin n_err++; $display("FAIL seq_wait: got %b expected 0", o_blob_seq); end
      i_blob_done = 1'b1; i_blob_count = 8'd3;
      step();
      i_blob_done = 1'b0;
      n_vec++; if (o_count !== 8'd3) begin n_err++; $display("FAIL basic_count: got %0d expected 3", o_count); end
      n_vec++; if (o_count_valid !== 1'b1) begin n_err++; $display("FAIL basic_cv: got %b expected 1", o_count_valid); end
      n_vec++; if (o_frames !== 16'd1) begin n_err++; $display("FAIL basic_frames: got %0d expected 1", o_frames); end
      n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %b expected 0", o_err); end
      step();
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL basic_idle: got %b expected 0", o_busy); end
      n_vec++; if (o_count_valid !== 1'b0) begin n_err++; $display("FAIL basic_cv_len: got %b expected 0", o_count_valid); end
      n_vec++; if (kick_cnt - kick0 !== 1) begin n_err++; $display("FAIL basic_kicks: got %0d expected 1", kick_cnt - kick0); end
      n_vec++; if (cv_cnt - cv0 !== 1) begin n_err++; $display("FAIL basic_cv_pulses: got %0d expected 1", cv_cnt - cv0); end
   endtask

   task automatic test_gap();
      int cv0;
      do_reset();
      cv0 = cv_cnt;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      drive_frame(32'hFFFF_FFFF, 10);
      n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL gap_err: got %b expected 1", o_err); end
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL gap_err_sticky: got %b expected 1", o_err); end
      i_blob_done = 1'b1; i_blob_count = 8'd5;
      step();
      i_blob_done = 1'b0;
      n_vec++; if (o_count !== 8'd0) begin n_err++; $display("FAIL gap_count: got %0d expected 0", o_count); end
      n_vec++; if (o_frames !== 16'd0) begin n_err++; $display("FAIL gap_frames: got %0d expected 0", o_frames); end
      step();
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL gap_idle: got %b expected 0", o_busy); end
      n_vec++; if (cv_cnt - cv0 !== 0) begin n_err++; $display("FAIL gap_cv_pulses: got %0d expected 0", cv_cnt - cv0); end
   endtask

   task automatic test_timeout();
      int kick0;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL err_clear: got %b expected 0", o_err); end
      drive_frame(32'h0000_1234, -1);
      for (int k = 1; k < int'(TIMEOUT); k++) begin
         step();
         n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL tmo_early[%0d]: got %b expected 0", k, o_err); end
      end
      step();
      n_vec++; if (o_err !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b expected 1", o_err); end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle: got %b expected 0", o_busy); end
      kick0 = kick_cnt;
      i_frame_start = 1'b1; i_blob_done = 1'b1; i_blob_count = 8'd9;
      step();
      i_frame_start = 1'b0; i_blob_done = 1'b0;
      step();
      n_vec++; if (kick_cnt - kick0 !== 0) begin n_err++; $display("FAIL tmo_no_kick: got %0d expected 0", kick_cnt - kick0); end
      n_vec++; if (o_count !== 8'd0) begin n_err++; $display("FAIL tmo_done_ignored: got %0d expected 0", o_count); end
   endtask

   task automatic test_overlap();
      int kick0;
      kick0 = kick_cnt;
      i_frame_start = 1'b1;
      step();
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL ovl_fs_idle: got %b expected 0", o_busy); end
      i_start = 1'b1;
      step();
      i_start = 1'b0; i_frame_start = 1'b0;
      n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL ovl_arm: got %b expected 1", o_busy); end
      n_vec++; if (o_blob_valid !== 1'b0) begin n_err++; $display("FAIL ovl_no_kick: got %b expected 0", o_blob_valid); end
      step();
      n_vec++; if (o_blob_valid !== 1'b0) begin n_err++; $display("FAIL ovl_no_kick2: got %b expected 0", o_blob_valid); end
      drive_frame(32'h8000_0001, -1);
      step();
      i_blob_done = 1'b1; i_blob_count = 8'd2;
      step();
      i_blob_done = 1'b0;
      step();
      n_vec++; if (kick_cnt - kick0 !== 1) begin n_err++; $display("FAIL ovl_kicks: got %0d expected 1", kick_cnt - kick0); end
   endtask

   task automatic test_continuous();
      logic [31:0] pats [3];
      logic [7:0]  res  [3];
      int cv0;
      int kick0;
      pats[0] = 32'h0000_00FF; pats[1] = 32'h0F0F_0F0F; pats[2] = 32'h1111_0000;
      res[0]  = 8'd1;          res[1]  = 8'd2;          res[2]  = 8'd4;
      do_reset();
      cv0 = cv_cnt; kick0 = kick_cnt;
      i_continuous = 1'b1;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int f = 0; f < 3; f++) begin
         drive_frame(pats[f], -1);
         step();
         if (f == 2) i_continuous = 1'b0;
         i_blob_done = 1'b1; i_blob_count = res[f];
         step();
         i_blob_done = 1'b0;
         n_vec++; if (o_count !== res[f]) begin n_err++; $display("FAIL cont_count[%0d]: got %0d expected %0d", f, o_count, res[f]); end
         step();
         n_vec++; if (o_busy !== (f < 2)) begin n_err++; $display("FAIL cont_rearm[%0d]: got %b expected %b", f, o_busy, (f < 2)); end
      end
      n_vec++; if (o_frames !== 16'd3) begin n_err++; $display("FAIL cont_frames: got %0d expected 3", o_frames); end
      n_vec++; if (cv_cnt - cv0 !== 3) begin n_err++; $display("FAIL cont_cv_pulses: got %0d expected 3", cv_cnt - cv0); end
      n_vec++; if (kick_cnt - kick0 !== 3) begin n_err++; $display("FAIL cont_kicks: got %0d expected 3", kick_cnt - kick0); end
   endtask

   task automatic test_reset_mid_stream();
      int kick0;
      i_start = 1'b1;
      step();
      i_start = 1'b0; i_frame_start = 1'b1;
      step();
      i_frame_start = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         i_pix_valid = 1'b1; i_pix_bin = 1'b1;
         step();
      end
      n_vec++; if (o_blob_seq !== 1'b1) begin n_err++; $display("FAIL mid_seq: got %b expected 1", o_blob_seq); end
      #2;
      i_rst_n = 1'b0;
      #1;
      n_vec++; if (o_blob_seq !== 1'b0) begin n_err++; $display("FAIL mid_rst_seq: got %b expected 0", o_blob_seq); end
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b expected 0", o_busy); end
      n_vec++; if (o_frames !== 16'd0) begin n_err++; $display("FAIL mid_rst_frames: got %0d expected 0", o_frames); end
      n_vec++; if (o_count !== 8'd0) begin n_err++; $display("FAIL mid_rst_count: got %0d expected 0", o_count); end
      i_pix_valid = 1'b0; i_pix_bin = 1'b0;
      step();
      i_rst_n = 1'b1;
      kick0 = kick_cnt;
      for (int i = 0; i < 4; i++) begin
         i_frame_start = (i % 2 == 0);
         step();
      end
      i_frame_start = 1'b0;
      step();
      n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL mid_idle: got %b expected 0", o_busy); end
      n_vec++; if (kick_cnt - kick0 !== 0) begin n_err++; $display("FAIL mid_no_kick: got %0d expected 0", kick_cnt - kick0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_timeout();
      test_overlap();
      test_continuous();
      test_reset_mid_stream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
